mdu_sequencer: RTL and testbench

Multi-cycle multiply/divide controller for the RV32M extension in the Execute stage of the pipelined core. It accepts one M-type operation from E, runs a 32-iteration shift-add multiply or restoring divide, and holds the pipeline through a stall line into the hazard unit. It presents a registered result for the single cycle in which the instruction leaves E. Divide-by-zero and signed-overflow cases take a one-cycle fast path.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_sequencer_if.sv | 23 ++
 rtl/mdu_divstep.sv | 21 ++
 rtl/mdu_sequencer.sv | 178 +++++++++++++++++
 tb/tb_mdu_sequencer.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared encodings and op classifiers for the RV32M multiply/divide sequencer
package mdu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] MD_MUL    = 3'b000;
    localparam logic [2:0] MD_MULH   = 3'b001;
    localparam logic [2:0] MD_MULHSU = 3'b010;
    localparam logic [2:0] MD_MULHU  = 3'b011;
    localparam logic [2:0] MD_DIV    = 3'b100;
    localparam logic [2:0] MD_DIVU   = 3'b101;
    localparam logic [2:0] MD_REM    = 3'b110;
    localparam logic [2:0] MD_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FAST = 2'd2,
        S_DONE = 2'd3
    } md_state_t;

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// rtl/mdu_sequencer_if.sv - Execute-stage handshake between the pipeline and the multiply/divide sequencer
interface mdu_sequencer_if;

    logic                       MdStartE;
    logic [2:0]                 MdOpE;
    logic [mdu_pkg::XLEN-1:0]   SrcAE;
    logic [mdu_pkg::XLEN-1:0]   SrcBE;
    logic                       MdKillE;
    logic                       MdStallE;
    logic                       MdDoneE;
    logic [mdu_pkg::XLEN-1:0]   MdResultE;

    modport master (
        output MdStartE, MdOpE, SrcAE, SrcBE, MdKillE,
        input  MdStallE, MdDoneE, MdResultE
    );

    modport slave (
        input  MdStartE, MdOpE, SrcAE, SrcBE, MdKillE,
        output MdStallE, MdDoneE, MdResultE
    );

endinterface

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one restoring-division step on unsigned magnitudes
module mdu_divstep
    import mdu_pkg::*;
(
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_bit,
    input  logic [XLEN-1:0] i_div,
    output logic [XLEN-1:0] o_rem,
    output logic            o_quo
);

    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;

    // The incoming remainder is below the divisor, so the difference always fits XLEN bits.
    assign w_shift = {i_rem, i_bit};
    assign o_quo   = (w_shift >= {1'b0, i_div});
    assign w_diff  = w_shift[XLEN-1:0] - i_div;
    assign o_rem   = o_quo ? w_diff : w_shift[XLEN-1:0];

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - multi-cycle RV32M multiply/divide controller with pipeline stall and fast special cases
module mdu_sequencer #(
    parameter int XLEN  = 32,
    parameter int ITERS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    mdu_sequencer_if.slave  md
);
    import mdu_pkg::*;

    localparam int            CW   = $clog2(ITERS);
    localparam logic [CW-1:0] LAST = CW'(ITERS - 1);

    md_state_t          r_state;
    md_state_t          w_state_nxt;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic               r_nega;
    logic               r_negb;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic [XLEN-1:0]    r_result;
    logic [2*XLEN-1:0]  r_acc;

    logic               w_nega_in;
    logic               w_negb_in;
    logic               w_fast_in;
    logic [XLEN-1:0]    w_maga;
    logic [XLEN-1:0]    w_magb;

    logic [XLEN:0]      w_sum;
    logic [2*XLEN-1:0]  w_mul_nxt;
    logic [2*XLEN-1:0]  w_div_nxt;
    logic [2*XLEN-1:0]  w_prod;
    logic [XLEN-1:0]    w_drem;
    logic               w_qbit;
    logic [XLEN-1:0]    w_quo;
    logic [XLEN-1:0]    w_rem;
    logic [XLEN-1:0]    w_final;
    logic [XLEN-1:0]    w_raw_a;
    logic [XLEN-1:0]    w_fast_res;

    // Capture-side decode: signs, magnitudes and the divide special cases.
    always_comb begin
        w_nega_in = is_signed_a(md.MdOpE) & md.SrcAE[XLEN-1];
        w_negb_in = is_signed_b(md.MdOpE) & md.SrcBE[XLEN-1];
        w_maga    = w_nega_in ? (~md.SrcAE + 1'b1) : md.SrcAE;
        w_magb    = w_negb_in ? (~md.SrcBE + 1'b1) : md.SrcBE;
        w_fast_in = is_div(md.MdOpE) &&
                    ((md.SrcBE == '0) ||
                     (is_signed_b(md.MdOpE) &&
                      (md.SrcAE == {1'b1, {(XLEN-1){1'b0}}}) &&
                      (md.SrcBE == '1)));
    end

    // Multiply: r_acc = {partial product high, remaining multiplier bits}, shifted right each step.
    assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_a} : {(XLEN+1){1'b0}});
    assign w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};

    // Divide: r_acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}.
    mdu_divstep u_divstep (
        .i_rem (r_acc[2*XLEN-1:XLEN]),
        .i_bit (r_acc[XLEN-1]),
        .i_div (r_b),
        .o_rem (w_drem),
        .o_quo (w_qbit)
    );

    assign w_div_nxt = {w_drem, r_acc[XLEN-2:0], w_qbit};

    always_comb begin
        w_prod  = (r_nega ^ r_negb) ? (~w_mul_nxt + 1'b1) : w_mul_nxt;
        w_quo   = (r_nega ^ r_negb) ? (~w_div_nxt[XLEN-1:0] + 1'b1) : w_div_nxt[XLEN-1:0];
        w_rem   = r_nega ? (~w_drem + 1'b1) : w_drem;
        w_final = w_rem;
        case (r_op)
            MD_MUL:                       w_final = w_prod[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:              w_final = w_quo;
            default:                      w_final = w_rem;
        endcase
    end

    // Fast path rebuilds the original dividend from its magnitude for divide-by-zero remainders.
    always_comb begin
        w_raw_a    = r_nega ? (~r_a + 1'b1) : r_a;
        w_fast_res = '0;
        if (r_b == '0) begin
            w_fast_res = ((r_op == MD_REM) || (r_op == MD_REMU)) ? w_raw_a : '1;
        end else begin
            w_fast_res = ((r_op == MD_REM) || (r_op == MD_REMU)) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        md.MdStallE  = 1'b0;
        md.MdDoneE   = 1'b0;
        case (r_state)
            S_IDLE: begin
                md.MdStallE = md.MdStartE;
                if (md.MdStartE) begin
                    w_state_nxt = w_fast_in ? S_FAST : S_CALC;
                end
            end
            S_CALC: begin
                md.MdStallE = 1'b1;
                if (r_cnt == LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_FAST: begin
                md.MdStallE = 1'b1;
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                md.MdDoneE  = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (md.MdKillE) begin
            w_state_nxt = S_IDLE;
        end
    end

    assign md.MdResultE = r_result;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_op     <= MD_MUL;
            r_nega   <= 1'b0;
            r_negb   <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
        end else if (md.MdKillE) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (md.MdStartE) begin
                        r_op   <= md.MdOpE;
                        r_nega <= w_nega_in;
                        r_negb <= w_negb_in;
                        r_a    <= w_maga;
                        r_b    <= w_magb;
                        r_acc  <= {{XLEN{1'b0}}, (is_div(md.MdOpE) ? w_maga : w_magb)};
                        r_cnt  <= '0;
                    end
                end
                S_CALC: begin
                    r_acc <= is_div(r_op) ? w_div_nxt : w_mul_nxt;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == LAST) begin
                        r_result <= w_final;
                    end
                end
                S_FAST: begin
                    r_result <= w_fast_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - randomized self-checking bench for mdu_sequencer against an arithmetic reference
module tb_mdu_sequencer;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mdu_sequencer_if md_if ();

    mdu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (md_if)
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] last_res = 32'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, r;
        logic [31:0] res;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'h0, a});
        ub  = longint'({32'h0, b});
        res = 32'h0;
        case (op)
            MD_MUL:    begin r = sa * sb; res = r[31:0];  end
            MD_MULH:   begin r = sa * sb; res = r[63:32]; end
            MD_MULHSU: begin r = sa * ub; res = r[63:32]; end
            MD_MULHU:  begin r = ua * ub; res = r[63:32]; end
            MD_DIV:    res = (b == 32'h0) ? 32'hFFFF_FFFF : 32'(sa / sb);
            MD_DIVU:   res = (b == 32'h0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            MD_REM:    res = (b == 32'h0) ? a : 32'(sa % sb);
            default:   res = (b == 32'h0) ? a : 32'(ua % ub);
        endcase
        return res;
    endfunction

    function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic sdiv;
        sdiv = (op == MD_DIV) || (op == MD_REM);
        if (op[2] && ((b == 32'h0) || (sdiv && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 2;
        return 33;
    endfunction

    task automatic drive_idle();
        md_if.MdStartE = 1'b0;
        md_if.MdKillE  = 1'b0;
        md_if.MdOpE    = 3'($urandom);
        md_if.SrcAE    = $urandom;
        md_if.SrcBE    = $urandom;
    endtask

    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        int cyc;
        int stall_miss;
        int lat;
        lat = ref_latency(op, a, b);
        @(negedge clk);
        md_if.MdStartE = 1'b1;
        md_if.MdOpE    = op;
        md_if.SrcAE    = a;
        md_if.SrcBE    = b;
        #1;
        cyc = 0;
        stall_miss = 0;
        while (md_if.MdDoneE !== 1'b1 && cyc < 40) begin
            if (md_if.MdStallE !== 1'b1) stall_miss++;
            @(negedge clk);
            drive_idle();
            #1;
            cyc++;
        end
        check({tag, ".lat"}, 32'(cyc), 32'(lat));
        check({tag, ".stall"}, 32'(stall_miss), 32'h0);
        check({tag, ".res"}, md_if.MdResultE, exp);
        check({tag, ".stall_done"}, {31'h0, md_if.MdStallE}, 32'h0);
        last_res = exp;
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;

        rst_n = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        check("rst.stall", {31'h0, md_if.MdStallE}, 32'h0);
        check("rst.done",  {31'h0, md_if.MdDoneE},  32'h0);
        check("rst.res",   md_if.MdResultE,         32'h0);
        rst_n = 1'b1;

        run_op(MD_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul");
        run_op(MD_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");
        run_op(MD_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, "mulh");
        run_op(MD_MULHSU, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, "mulhsu");
        run_op(MD_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div");
        run_op(MD_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_b2b");
        run_op(MD_DIVU,   32'd100,        32'd7,         32'd14,        "divu");
        run_op(MD_REMU,   32'd100,        32'd7,         32'd2,         "remu");
        run_op(MD_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, "divu0");
        run_op(MD_REMU,   32'd5,          32'd0,         32'd5,         "remu0");
        run_op(MD_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run_op(MD_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         "rem_ovf");
        run_op(MD_REM,    32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFB, "rem0_neg");

        // Kill at iteration 10 of a multiply.
        @(negedge clk);
        md_if.MdStartE = 1'b1;
        md_if.MdOpE    = MD_MUL;
        md_if.SrcAE    = $urandom;
        md_if.SrcBE    = $urandom;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive_idle();
        end
        md_if.MdKillE = 1'b1;
        @(negedge clk);
        md_if.MdKillE = 1'b0;
        #1;
        check("kill.stall", {31'h0, md_if.MdStallE}, 32'h0);
        check("kill.done",  {31'h0, md_if.MdDoneE},  32'h0);
        check("kill.res",   md_if.MdResultE,         last_res);
        @(negedge clk);
        #1;
        check("kill.done2", {31'h0, md_if.MdDoneE},  32'h0);
        run_op(MD_MUL, 32'd12345, 32'd678, 32'd8369910, "after_kill");

        // Reset at iteration 20 of a divide.
        @(negedge clk);
        md_if.MdStartE = 1'b1;
        md_if.MdOpE    = MD_DIVU;
        md_if.SrcAE    = 32'd1000;
        md_if.SrcBE    = 32'd3;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive_idle();
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        last_res = 32'h0;
        check("rstcalc.stall", {31'h0, md_if.MdStallE}, 32'h0);
        check("rstcalc.done",  {31'h0, md_if.MdDoneE},  32'h0);
        check("rstcalc.res",   md_if.MdResultE,         32'h0);

        // Kill and start together in IDLE: nothing captured.
        @(negedge clk);
        md_if.MdStartE = 1'b1;
        md_if.MdKillE  = 1'b1;
        md_if.MdOpE    = MD_DIVU;
        md_if.SrcAE    = 32'd5;
        md_if.SrcBE    = 32'd0;
        @(negedge clk);
        drive_idle();
        #1;
        check("killstart.stall", {31'h0, md_if.MdStallE}, 32'h0);
        check("killstart.done",  {31'h0, md_if.MdDoneE},  32'h0);
        @(negedge clk);
        #1;
        check("killstart.done2", {31'h0, md_if.MdDoneE},  32'h0);
        check("killstart.res",   md_if.MdResultE,         32'h0);

        for (int n = 0; n < 48; n++) begin
            op = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       b = 32'h0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            run_op(op, a, b, ref_md(op, a, b), $sformatf("rnd%0d_op%0d", n, op));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
